// File: rtl/if_id_stage_q.sv
// IF-ID pipeline stage: synchronous-read dual-port instruction RAM plus the PC segment register.
// Port A fetches for the pipeline; port B is a byte-writable debug/loader port.
module if_id_stage_q #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic [31:0] pc_f,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic        misalign_d,
  output logic        range_err_d,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [3:0]  dbg_we,
  output logic [31:0] dbg_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           mem [0:DEPTH-1];
  logic [31:0]           ram_q;
  logic [31:0]           hold_q;
  logic                  stall_q;
  logic                  bubble_q;
  logic [ADDR_WIDTH-1:0] a_idx;
  logic [ADDR_WIDTH-1:0] b_idx;

  // Debug address bits outside the word index simply wrap.
  logic unused_dbg_bits;
  assign unused_dbg_bits = ^{dbg_addr[1:0], dbg_addr[31:ADDR_WIDTH+2]};

  assign a_idx = pc_f[ADDR_WIDTH+1:2];
  assign b_idx = dbg_addr[ADDR_WIDTH+1:2];

  // Both ports are read-first: a same-word collision returns the pre-write word.
  always_ff @(posedge clk) begin
    ram_q     <= mem[a_idx];
    dbg_rdata <= mem[b_idx];
    for (int i = 0; i < 4; i++) begin
      if (dbg_we[i]) begin
        mem[b_idx][8*i +: 8] <= dbg_wdata[8*i +: 8];
      end
    end
  end

  // Stage control: en=0 stalls (clear ignored); en=1 with clear injects a bubble;
  // otherwise the PC on pc_f is loaded. rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_d        <= '0;
      valid_d     <= 1'b0;
      misalign_d  <= 1'b0;
      range_err_d <= 1'b0;
      stall_q     <= 1'b0;
      bubble_q    <= 1'b1;
      hold_q      <= NOP_INSTR;
    end else begin
      hold_q <= instr_d;
      if (!en) begin
        stall_q <= 1'b1;
      end else if (clear) begin
        pc_d        <= '0;
        valid_d     <= 1'b0;
        misalign_d  <= 1'b0;
        range_err_d <= 1'b0;
        stall_q     <= 1'b0;
        bubble_q    <= 1'b1;
      end else begin
        pc_d        <= pc_f;
        valid_d     <= 1'b1;
        misalign_d  <= |pc_f[1:0];
        range_err_d <= |pc_f[31:ADDR_WIDTH+2];
        stall_q     <= 1'b0;
        bubble_q    <= 1'b0;
      end
    end
  end

  // During a stall the RAM keeps reading whatever is on pc_f, so the held word is replayed.
  always_comb begin
    instr_d = ram_q;
    if (stall_q) begin
      instr_d = hold_q;
    end else if (bubble_q || range_err_d || misalign_d) begin
      instr_d = NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_if_id_stage_q.sv
// Directed bench for if_id_stage_q: each step pushes its expected ID outputs to a queue,
// and the entry is popped and checked one edge later.
module tb_if_id_stage_q;

    localparam int          AW  = 10;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, en, clear;
    logic [31:0] pc_f, pc_d, instr_d;
    logic        valid_d, misalign_d, range_err_d;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [3:0]  dbg_we;

    logic [66:0] exp_q[$];
    logic [31:0] dbg_exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] a [0:5];
    logic [31:0] patched;

    if_id_stage_q #(.ADDR_WIDTH(AW), .NOP_INSTR(NOP), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .pc_f(pc_f),
        .pc_d(pc_d), .instr_d(instr_d), .valid_d(valid_d),
        .misalign_d(misalign_d), .range_err_d(range_err_d),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we),
        .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic dbg_set(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
        dbg_addr  = addr;
        dbg_wdata = data;
        dbg_we    = we;
    endtask

    // Drive one edge's controls, queue the expected ID outputs, then check after the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic c,
                        input logic [31:0] pc, input logic [31:0] epc, input logic [31:0] ein,
                        input logic ev, input logic em, input logic er);
        logic [66:0] obs, expv;
        logic [31:0] dobs, dexp;
        rst   = r;
        en    = e;
        clear = c;
        pc_f  = pc;
        exp_q.push_back({epc, ein, ev, em, er});
        @(posedge clk);
        #1;
        expv = exp_q.pop_front();
        obs  = {pc_d, instr_d, valid_d, misalign_d, range_err_d};
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s obs pc=%h instr=%h v/m/r=%b exp pc=%h instr=%h v/m/r=%b",
                   tag, obs[66:35], obs[34:3], obs[2:0], expv[66:35], expv[34:3], expv[2:0]);
        end
        if (dbg_exp_q.size() != 0) begin
            dexp = dbg_exp_q.pop_front();
            dobs = dbg_rdata;
            total++;
            assert (dobs === dexp) else begin
                bad++;
                $error("FAIL %s_dbg obs=%h exp=%h", tag, dobs, dexp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clear = 1'b0; pc_f = '0;
        dbg_set('0, '0, 4'b0000);
        for (int i = 0; i < 6; i++) a[i] = $urandom();

        // Load the image through port B while reset is held; outputs must sit at reset values.
        for (int i = 0; i < 4; i++) begin
            dbg_set(32'(i * 4), a[i], 4'b1111);
            step("rst_load", 1, 0, 0, 0, 0, NOP, 0, 0, 0);
        end
        dbg_set(32'h0000_1010, a[4], 4'b1111);
        step("rst_wrap_wr", 1, 1, 1, 0, 0, NOP, 0, 0, 0);
        dbg_set(32'h0000_0FFC, a[5], 4'b1111);
        step("rst_top_wr", 1, 1, 0, 32'h8, 0, NOP, 0, 0, 0);
        dbg_set(32'h0000_0010, '0, 4'b0000);

        // T1: straight fetch stream
        step("t1_pc0", 0, 1, 0, 32'h0, 32'h0, a[0], 1, 0, 0);
        step("t1_pc4", 0, 1, 0, 32'h4, 32'h4, a[1], 1, 0, 0);
        step("t1_pc8", 0, 1, 0, 32'h8, 32'h8, a[2], 1, 0, 0);
        step("t1_pc4b", 0, 1, 0, 32'h4, 32'h4, a[1], 1, 0, 0);

        // T2: three-cycle stall while pc_f wanders; clear is ignored during a stall
        for (int i = 0; i < 3; i++)
            step("t2_stall", 0, 0, 1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00},
                 32'h4, a[1], 1, 0, 0);
        step("t2_resume", 0, 1, 0, 32'h8, 32'h8, a[2], 1, 0, 0);

        // T3: flush bubble, then clear with en=0 must stall instead
        step("t3_bubble", 0, 1, 1, 32'h4, 32'h0, NOP, 0, 0, 0);
        step("t3_reload", 0, 1, 0, 32'h0, 32'h0, a[0], 1, 0, 0);
        step("t3_stallwin", 0, 0, 1, 32'h4, 32'h0, a[0], 1, 0, 0);
        step("t3_after", 0, 1, 0, 32'hC, 32'hC, a[3], 1, 0, 0);

        // T4: misaligned, out of range, last in-range word, wrapped debug write
        step("t4_misalign", 0, 1, 0, 32'h2, 32'h2, NOP, 1, 1, 0);
        step("t4_range", 0, 1, 0, 32'h1000, 32'h1000, NOP, 1, 0, 1);
        step("t4_range_hi", 0, 1, 0, 32'h8000_0004, 32'h8000_0004, NOP, 1, 0, 1);
        step("t4_topword", 0, 1, 0, 32'hFFC, 32'hFFC, a[5], 1, 0, 0);
        dbg_exp_q.push_back(a[4]);
        step("t4_wrapword", 0, 1, 0, 32'h10, 32'h10, a[4], 1, 0, 0);

        // T5: same-word collision, both ports read-first
        patched = {a[1][31:16], 16'hBEEF};
        dbg_set(32'h4, 32'hDEADBEEF, 4'b0011);
        dbg_exp_q.push_back(a[1]);
        step("t5_collide", 0, 1, 0, 32'h4, 32'h4, a[1], 1, 0, 0);
        dbg_set(32'h4, '0, 4'b0000);
        dbg_exp_q.push_back(patched);
        step("t5_newdata", 0, 1, 0, 32'h4, 32'h4, patched, 1, 0, 0);

        // T6: reset during a stall and during a flush; no stale held word afterwards
        step("t6_stall", 0, 0, 0, 32'h8, 32'h4, patched, 1, 0, 0);
        step("t6_rst_stall", 1, 0, 0, 32'h8, 32'h0, NOP, 0, 0, 0);
        step("t6_post_stall", 0, 0, 0, 32'h8, 32'h0, NOP, 0, 0, 0);
        step("t6_load", 0, 1, 0, 32'h8, 32'h8, a[2], 1, 0, 0);
        step("t6_rst_clear", 1, 1, 1, 32'hC, 32'h0, NOP, 0, 0, 0);
        step("t6_load2", 0, 1, 0, 32'h0, 32'h0, a[0], 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
